// File: rtl/dbg_page_mux.sv
// Debug-display front end: debounces three buttons, keeps reg/page/mode state
// and packs the selected page of probe words into the registered LCD number bus.

module dbg_debounce #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_pulse
);
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          r_s1, r_s2, r_lvl, r_pulse;
  logic [CW-1:0] r_cnt;

  // The counter measures how long the synchronised input has disagreed with
  // the accepted level; the level flips once that run reaches DEB_CYC samples.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl   <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_pulse <= 1'b0;
      if (r_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYC - 1)) begin
        r_lvl   <= r_s2;
        r_cnt   <= '0;
        r_pulse <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;
endmodule

module dbg_page_mux #(
  parameter int CH_W       = 32,
  parameter int NUM_CH     = 8,
  parameter int SLOTS      = 4,
  parameter int REG_W      = 5,
  parameter int TAG_EN     = 1,
  parameter int TAG_LSB    = 24,
  parameter int DEB_CYC    = 500000,
  parameter int SCROLL_CYC = 50000000,
  localparam int PAGES     = NUM_CH / SLOTS,
  localparam int PG_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic                    btn_reg,
  input  logic                    btn_page,
  input  logic                    btn_mode,
  input  logic [NUM_CH*CH_W-1:0]  ch_data,
  output logic [REG_W-1:0]        reg_num,
  output logic [PG_W-1:0]         page,
  output logic [1:0]              mode,
  output logic [SLOTS*CH_W-1:0]   num_out
);
  localparam int SC_W = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;

  typedef enum logic [1:0] {M_LIVE = 2'd0, M_AUTO = 2'd1, M_HOLD = 2'd2, M_BAD = 2'd3} mode_e;

  logic [2:0] w_raw, w_pulse;
  assign w_raw = {btn_mode, btn_page, btn_reg};

  for (genvar g = 0; g < 3; g++) begin : g_deb
    dbg_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .i_raw   (w_raw[g]),
      .o_pulse (w_pulse[g])
    );
  end

  mode_e                        r_mode, w_mode_nxt;
  logic [REG_W-1:0]             r_reg;
  logic [PG_W-1:0]              r_page, w_page_nxt;
  logic [SC_W-1:0]              r_scnt;
  logic                         w_tick;
  logic [SLOTS*CH_W-1:0]        r_num;

  assign w_tick = (r_mode == M_AUTO) && (r_scnt == SC_W'(SCROLL_CYC - 1));

  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      M_LIVE:  if (w_pulse[2]) w_mode_nxt = M_AUTO;
      M_AUTO:  if (w_pulse[2]) w_mode_nxt = M_HOLD;
      M_HOLD:  if (w_pulse[2]) w_mode_nxt = M_LIVE;
      default: w_mode_nxt = M_LIVE;
    endcase
  end

  // Manual press and scroll tick coinciding still advance by one page.
  always_comb begin
    w_page_nxt = r_page;
    if (w_pulse[1] || w_tick)
      w_page_nxt = (r_page == PG_W'(PAGES - 1)) ? '0 : r_page + 1'b1;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      r_mode <= M_LIVE;
      r_reg  <= '0;
      r_page <= '0;
      r_scnt <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_reg  <= r_reg + REG_W'(w_pulse[0]);
      r_page <= w_page_nxt;
      // Held at zero outside AUTO, so entering AUTO always starts a fresh dwell.
      if (r_mode != M_AUTO || w_pulse[1] || w_tick) r_scnt <= '0;
      else                                          r_scnt <= r_scnt + 1'b1;
    end
  end

  logic [PAGES-1:0][SLOTS-1:0][CH_W-1:0] w_pages;
  logic [SLOTS-1:0][CH_W-1:0]            w_live;
  logic [CH_W-1:0]                       w_tag;

  assign w_pages = ch_data;
  assign w_tag   = CH_W'(r_reg) << TAG_LSB;

  always_comb begin
    w_live = w_pages[r_page];
    if (TAG_EN != 0) w_live[0] = w_live[0] | w_tag;
  end

  // The edge that enters HOLD still sees the old mode, capturing a final live value.
  always_ff @(posedge clk_50M) begin
    if (!rst_n)                r_num <= '0;
    else if (r_mode != M_HOLD) r_num <= w_live;
  end

  assign reg_num = r_reg;
  assign page    = r_page;
  assign mode    = r_mode;
  assign num_out = r_num;
endmodule

// File: tb/tb_dbg_page_mux.sv
// Bench for dbg_page_mux: directed steps plus random button traffic, compared
// every cycle against a sliding-window / event-time reference model.

module tb_dbg_page_mux;
  localparam int CH_W = 32, NUM_CH = 8, SLOTS = 4, REG_W = 5, TAG_LSB = 24;
  localparam int DEB = 4, SCR = 8, PAGES = NUM_CH / SLOTS;

  logic clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic                   rst_n, btn_reg, btn_page, btn_mode;
  logic [NUM_CH*CH_W-1:0] ch_data;
  logic [REG_W-1:0]       reg_num;
  logic [0:0]             page;
  logic [1:0]             mode;
  logic [SLOTS*CH_W-1:0]  num_out;

  dbg_page_mux #(
    .CH_W(CH_W), .NUM_CH(NUM_CH), .SLOTS(SLOTS), .REG_W(REG_W), .TAG_EN(1),
    .TAG_LSB(TAG_LSB), .DEB_CYC(DEB), .SCROLL_CYC(SCR)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .btn_reg(btn_reg), .btn_page(btn_page),
    .btn_mode(btn_mode), .ch_data(ch_data), .reg_num(reg_num), .page(page),
    .mode(mode), .num_out(num_out)
  );

  int nvec = 0, nerr = 0;

  // Reference state: accepted button levels, raw sample history (bit 0 newest),
  // press pending for the next edge, and the edge number where the dwell began.
  logic [2:0]     m_lvl, m_pend;
  logic [DEB+1:0] m_hist [3];
  int             m_reg, m_page, m_mode, cyc, ds;
  logic [127:0]   m_num;

  function automatic logic [127:0] live_val();
    logic [127:0] v;
    logic [31:0]  w;
    v = '0;
    for (int s = 0; s < SLOTS; s++) begin
      w = ch_data[(m_page * SLOTS + s) * CH_W +: CH_W];
      if (s == 0) w = w | (32'(m_reg) << TAG_LSB);
      v[s*CH_W +: CH_W] = w;
    end
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] raw);
    logic [2:0] p;
    logic       tick, flip;
    int         old_mode;
    cyc++;
    if (!r) begin
      m_lvl = '0; m_pend = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
      m_reg = 0; m_page = 0; m_mode = 0; m_num = '0;
      return;
    end
    p        = m_pend;
    old_mode = m_mode;
    tick     = (m_mode == 1) && (cyc - ds == SCR);
    if (old_mode != 2) m_num = live_val();
    m_reg = (m_reg + int'(p[0])) % 32;
    if (p[1] || tick) m_page = (m_page + 1) % PAGES;
    if (p[2]) m_mode = (m_mode + 1) % 3;
    if ((m_mode == 1 && old_mode != 1) || p[1] || tick) ds = cyc;
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][DEB:0], raw[b]};
      m_pend[b] = 1'b0;
      flip = 1'b1;
      for (int k = 0; k < DEB; k++)
        if (m_hist[b][2+k] == m_lvl[b]) flip = 1'b0;
      if (flip) begin
        m_lvl[b]  = ~m_lvl[b];
        m_pend[b] = m_lvl[b];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] b);
    rst_n = r;
    {btn_mode, btn_page, btn_reg} = b;
    @(posedge clk_50M);
    model_edge(r, b);
    #1;
    chk("reg_num", 128'(reg_num), 128'(m_reg));
    chk("page",    128'(page),    128'(m_page));
    chk("mode",    128'(mode),    128'(m_mode));
    chk("num_out", num_out,       m_num);
  endtask

  task automatic press(input int b);
    for (int i = 0; i < 7; i++) step(1'b1, 3'(1 << b));
    for (int i = 0; i < 7; i++) step(1'b1, 3'b000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 3'b000);
  endtask

  initial begin
    logic [127:0] init_exp;
    cyc = 0; ds = 0;
    rst_n = 1'b0; btn_reg = 1'b0; btn_page = 1'b0; btn_mode = 1'b0;
    for (int k = 0; k < NUM_CH; k++) ch_data[k*CH_W +: CH_W] = 32'h1000_0000 + 32'(k);
    init_exp = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};

    for (int i = 0; i < 3; i++) step(1'b0, 3'b000);
    chk("rst_num_out", num_out, 128'd0);
    step(1'b1, 3'b000);
    chk("num_init", num_out, init_exp);

    // Short glitch must not register.
    for (int i = 0; i < 3; i++) step(1'b1, 3'b001);
    idle(8);
    chk("glitch_reg", 128'(reg_num), 128'd0);

    // Held press: count lands exactly 6 edges after the first high sample.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'b001);
      if (i == 5) chk("lat_before", 128'(reg_num), 128'd0);
      if (i == 6) chk("lat_at",     128'(reg_num), 128'd1);
      if (i == 7) chk("tag_slot0",  128'(num_out[31:0]), 128'(32'h1100_0000));
    end
    idle(7);

    for (int i = 0; i < 31; i++) press(0);
    chk("reg_wrap", 128'(reg_num), 128'd0);

    press(1);
    chk("page1", 128'(page), 128'd1);
    chk("page1_slot0", 128'(num_out[31:0]), 128'(32'h1000_0004));
    press(1);
    chk("page0", 128'(page), 128'd0);

    // AUTO scroll, with a manual page press in the middle of a dwell.
    press(2);
    idle(19);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b010);
    idle(20);

    // HOLD: data and page change but the bus stays frozen.
    press(2);
    for (int k = 0; k < NUM_CH; k++) ch_data[k*CH_W +: CH_W] = $urandom();
    press(1);
    idle(4);
    press(2);
    idle(3);

    // Reset mid-debounce, then mid-scroll.
    step(1'b1, 3'b001); step(1'b1, 3'b001);
    step(1'b0, 3'b001);
    for (int i = 0; i < 8; i++) step(1'b1, 3'b001);
    idle(7);
    press(2);
    idle(5);
    step(1'b0, 3'b000); step(1'b0, 3'b000);
    idle(10);

    // Random traffic: bursts of mixed button levels, data churn, stray resets.
    for (int seg = 0; seg < 150; seg++) begin
      logic [2:0] b;
      int         len;
      b   = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 7) == 0)
        ch_data[$urandom_range(0, NUM_CH-1)*CH_W +: CH_W] = $urandom();
      if ($urandom_range(0, 24) == 0) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) step(1'b0, b);
      end
      for (int i = 0; i < len; i++) step(1'b1, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
